// File: rtl/vector_multiplier_pkg.sv
// Shared matrix-engine package: element sizing defaults and packing helpers.
// Elements of a packed vector sit at bits [w*i +: w], lowest index at LSB.
package vector_multiplier_pkg;

  localparam int DIM_DEF = 8;
  localparam int W_DEF   = 16;

  // Full-precision product width for a w-bit unsigned element.
  function automatic int pw_of(input int w);
    return 2 * w;
  endfunction

  // LSB position of element i in a vector of w-bit elements.
  function automatic int elem_lo(input int i, input int w);
    return i * w;
  endfunction

  // Bits needed to index n items (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vector_multiplier_mult_lane.sv
// One unsigned W x W multiply lane with registered, enabled PW-bit result.
// Ports: Clock, en (load), a, b (operands), p (registered product).
module mult_lane #(
  parameter int W  = 16,
  parameter int PW = 2 * W
) (
  input  logic          Clock,
  input  logic          en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);

  always_ff @(posedge Clock) begin
    if (en) p <= PW'(a) * PW'(b);
  end

endmodule

// File: rtl/vector_multiplier.sv
// Two-stage element-wise vector multiplier with valid/ready on both sides.
// Ports: Clock, Reset, in_valid/in_ready/vec_a/vec_b, out_valid/out_ready/product, done_count.
module vector_multiplier
  import vector_multiplier_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int W   = W_DEF
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIM*W-1:0]        vec_a,
  input  logic [DIM*W-1:0]        vec_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIM*pw_of(W)-1:0] product,
  output logic [15:0]             done_count
);

  localparam int PW = pw_of(W);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             s1_load;
  logic             s2_load;
  logic [DIM*W-1:0] a_q;
  logic [DIM*W-1:0] b_q;

  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Reset empties both stages, so the block is ready while it is held.
  assign in_ready  = Reset || s1_adv;
  assign out_valid = s2_valid;

  assign s1_load = !Reset && s1_adv && in_valid;
  // Product only reloads when a valid pair moves in, keeping it stable otherwise.
  assign s2_load = !Reset && s2_adv && s1_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      done_count <= 16'd0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_valid && out_ready) done_count <= done_count + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (s1_load) begin
      a_q <= vec_a;
      b_q <= vec_b;
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam int LO = elem_lo(i, W);
    localparam int PO = elem_lo(i, PW);
    mult_lane #(
      .W  (W),
      .PW (PW)
    ) u_lane (
      .Clock (Clock),
      .en    (s2_load),
      .a     (a_q[LO +: W]),
      .b     (b_q[LO +: W]),
      .p     (product[PO +: PW])
    );
  end

endmodule

// File: tb/tb_vector_multiplier.sv
// Directed bench for vector_multiplier (DIM=8, W=16) with a product queue.
// Covers latency, overflow width, backpressure, streaming, reset and wrap.
module tb_vector_multiplier;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] vec_a = '0;
  logic [127:0] vec_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] product;
  logic [15:0]  done_count;

  int total = 0;
  int bad = 0;
  int out_n = 0;
  logic [15:0]  dc_exp = 16'd0;
  logic         last_in;
  logic [255:0] q[$];

  always #5 Clock = ~Clock;

  vector_multiplier u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vec_a      (vec_a),
    .vec_b      (vec_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .done_count (done_count)
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mulv(input logic [127:0] a,
                                        input logic [127:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[32*i +: 32] = 32'(a[16*i +: 16]) * 32'(b[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [127:0] splat(input logic [15:0] v);
    return {8{v}};
  endfunction

  // One clock: score transfers seen before the edge, then check the counter.
  task automatic step();
    logic in_f;
    logic out_f;
    #1;
    in_f  = in_valid && in_ready && !Reset;
    out_f = out_valid && out_ready && !Reset;
    last_in = in_f;
    if (Reset) begin
      q.delete();
      dc_exp = 16'd0;
    end else begin
      if (out_f) begin
        if (q.size() == 0) chk("dup", 256'(out_valid), 256'd0);
        else chk("order", product, q.pop_front());
        dc_exp++;
        out_n++;
      end
      if (in_f) q.push_back(mulv(vec_a, vec_b));
    end
    @(posedge Clock);
    #1;
    chk("done_count", 256'(done_count), 256'(dc_exp));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    int start;
    logic [127:0] av[3];
    logic [127:0] bv[3];

    // Reset state
    step();
    step();
    Reset = 1'b0;
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_done", 256'(done_count), 256'd0);

    // Basic latency: a = 1..8, b = 2
    vec_a = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vec_b = splat(16'd2);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_c1_valid", 256'(out_valid), 256'd0);
    step();
    chk("lat_c2_valid", 256'(out_valid), 256'd1);
    chk("lat_prod", product,
        {32'd16, 32'd14, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2});
    step();
    chk("lat_done", 256'(done_count), 256'd1);
    chk("lat_drain", 256'(out_valid), 256'd0);

    // Overflow width
    vec_a = splat(16'hFFFF);
    vec_b = splat(16'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("ovf_valid", 256'(out_valid), 256'd1);
    chk("ovf_prod", product, {8{32'hFFFE0001}});
    step();

    // Backpressure: three pairs, consumer stalled
    av[0] = splat(16'd3);  bv[0] = splat(16'd5);
    av[1] = splat(16'd7);  bv[1] = splat(16'd11);
    av[2] = splat(16'd13); bv[2] = splat(16'd17);
    out_ready = 1'b0;
    start = out_n;
    k = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      vec_a = av[k];
      vec_b = bv[k];
      in_valid = 1'b1;
      step();
      if (last_in) k++;
      cyc++;
    end
    chk("bp_accepted", 256'(k), 256'd2);
    vec_a = av[2];
    vec_b = bv[2];
    repeat (3) step();
    chk("bp_in_ready", 256'(in_ready), 256'd0);
    chk("bp_hold_valid", 256'(out_valid), 256'd1);
    chk("bp_hold_prod", product, {8{32'd15}});
    out_ready = 1'b1;
    cyc = 0;
    while ((k < 3 || q.size() != 0) && cyc < 20) begin
      step();
      if (last_in) begin
        k++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    step();
    chk("bp_out_count", 256'(out_n - start), 256'd3);

    // Streaming with random handshakes
    do_reset();
    start = out_n;
    k = 0;
    cyc = 0;
    vec_a = 128'({$urandom, $urandom, $urandom, $urandom});
    vec_b = 128'({$urandom, $urandom, $urandom, $urandom});
    while ((out_n - start) < 20 && cyc < 1000) begin
      in_valid = (k < 20) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (last_in) begin
        k++;
        vec_a = 128'({$urandom, $urandom, $urandom, $urandom});
        vec_b = 128'({$urandom, $urandom, $urandom, $urandom});
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_out_count", 256'(out_n - start), 256'd20);
    chk("stream_done", 256'(done_count), 256'd20);

    // Mid-operation reset with both stages full
    out_ready = 1'b0;
    vec_a = splat(16'd9);
    vec_b = splat(16'd9);
    in_valid = 1'b1;
    step();
    step();
    #1;
    chk("mr_full_in_ready", 256'(in_ready), 256'd0);
    Reset = 1'b1;
    #1;
    chk("mr_in_ready_rst", 256'(in_ready), 256'd1);
    step();
    Reset = 1'b0;
    in_valid = 1'b0;
    chk("mr_out_valid", 256'(out_valid), 256'd0);
    chk("mr_in_ready", 256'(in_ready), 256'd1);
    chk("mr_done", 256'(done_count), 256'd0);
    out_ready = 1'b1;
    start = out_n;
    repeat (4) step();
    chk("mr_no_stale", 256'(out_n - start), 256'd0);

    // Counter wrap after 65536 transfers
    do_reset();
    vec_a = splat(16'd1);
    vec_b = splat(16'd1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    start = out_n;
    cyc = 0;
    while ((out_n - start) < 65536 && cyc < 70000) begin
      step();
      if ((out_n - start) == 65535)
        chk("wrap_ffff", 256'(done_count), 256'hFFFF);
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap_count", 256'(out_n - start), 256'd65536);
    chk("wrap_zero", 256'(done_count), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_multiplier.md
VECTOR_MULTIPLIER -- requirements
Module: vector_multiplier

Interface
REQ-001 SHALL have parameter DIM, default 8: number of elements per vector; power of 2, >= 2.
REQ-002 SHALL have parameter W, default 16: unsigned element width.
REQ-003 SHALL have localparam PW = 2*W: product element width.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state changes on posedge Clock.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: vec_a and vec_b hold a valid operand pair.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-008 SHALL have port vec_a, input, DIM*W bits: row operand; element i at bits [W*i +: W].
REQ-009 SHALL have port vec_b, input, DIM*W bits: column operand; same packing as vec_a.
REQ-010 SHALL have port out_valid, output, 1 bit: product holds a valid result.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream parallel_adder-side consumer accepts product this cycle.
REQ-012 SHALL have port product, output, DIM*PW bits: element-wise products; element i at bits [PW*i +: PW].
REQ-013 SHALL have port done_count, output, 16 bits: number of results delivered since reset.

Function
REQ-014 SHALL count an input transfer only on a posedge Clock where in_valid && in_ready; an output transfer only where out_valid && out_ready.
REQ-015 SHALL form a 2-stage pipeline: S1 registers vec_a/vec_b and a valid bit; S2 registers the DIM products and a valid bit.
REQ-016 SHALL compute product element i = vec_a[i] * vec_b[i], unsigned, full PW bits, no truncation or saturation.
REQ-017 SHALL present out_valid exactly 2 cycles after the input transfer when there is no backpressure; throughput is 1 pair per cycle.
REQ-018 SHALL drive out_valid = S2 valid bit.
REQ-019 SHALL define S2 advance as !S2valid || out_ready.
REQ-020 SHALL define S1 advance as !S1valid || S2 advance.
REQ-021 SHALL drive in_ready = S1 advance, combinationally, with no dependency on in_valid.
REQ-022 SHALL, while out_valid && !out_ready, hold product and out_valid stable; S1 also holds if valid.
REQ-023 SHALL lose and duplicate no data: with both stages full and stalled, in_ready = 0.
REQ-024 SHALL clear a stage's valid bit when it advances with no new data entering it; data registers may keep stale values.
REQ-025 SHALL keep product unchanged while out_valid = 0, so it is don't-care but stable.
REQ-026 SHALL increment done_count by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-027 SHALL handle a simultaneous S2 output transfer and S1-to-S2 move in one cycle, with out_valid remaining 1 and no bubble.

Reset
REQ-028 SHALL, when Reset = 1 at posedge Clock, clear S1valid, S2valid and done_count to 0; out_valid = 0, and product and operand registers need not be cleared.
REQ-029 SHALL hold in_ready = 1 while Reset is asserted and from the first cycle after it deasserts.
REQ-030 SHALL abort in-flight data when Reset is asserted mid-operation: no output transfer for pairs accepted before reset.
REQ-031 SHALL ignore an input transfer in the same cycle as Reset = 1.

Structure
REQ-032 SHALL place DIM/W defaults, PW derivation and the element-index packing helpers in the shared matrix-engine package, with CLOG2 kept with them.
REQ-033 SHALL instantiate one sub-module, mult_lane (W-bit x W-bit -> PW-bit registered multiply with enable), DIM times via generate.
REQ-034 SHALL use the same packing as parallel_adder's vector input, so product connects directly to a parallel_adder with element width PW.

Verification
REQ-035 SHALL cover basic latency: DIM=8, W=16, vec_a elements = 1..8, vec_b all = 2, out_ready = 1 -> 2 cycles later out_valid = 1, product = 2,4,...,16, done_count = 1.
REQ-036 SHALL cover overflow width: every element 0xFFFF x 0xFFFF -> every product element 0xFFFE0001.
REQ-037 SHALL cover backpressure: 3 back-to-back pairs (A0..A2) with out_ready = 0 -> in_ready falls after 2 accepted; raise out_ready -> exactly 3 results in order, no repeats.
REQ-038 SHALL cover streaming: 20 pairs with random in_valid/out_ready -> scoreboard matches, done_count = 20.
REQ-039 SHALL cover mid-operation reset: Reset pulsed with both stages full -> next cycle out_valid = 0, in_ready = 1, done_count = 0, no stale output afterward.
REQ-040 SHALL cover wrap: force 65536 transfers -> done_count returns to 0x0000.
